// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory request arbiter.
//   - line payload widths (address, data, byte mask)
//   - requester index constants
//   - arbiter FSM state encoding
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int MASK_W = 16;
    localparam int N_REQ  = 2;

    // A write slot stores {addr, data, mask}; a read slot stores addr only.
    localparam int WPAY_W = ADDR_W + DATA_W + MASK_W;

    localparam int REQ_UART = 0;
    localparam int REQ_DC   = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_W = 2'd2,
        WAIT_R = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_req_slot.sv
// One pending-request slot: valid bit plus payload register.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   set       - request pulse; captures pay_in when the slot is free
//   clr       - slot is being issued this cycle
//   pay_in    - payload presented with the pulse
//   valid     - slot holds a pending request
//   pay       - stored payload
//   overrun   - pulse dropped because the slot was already occupied
module mem_req_slot #(
    parameter int PAY_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic             clr,
    input  logic [PAY_W-1:0] pay_in,
    output logic             valid,
    output logic [PAY_W-1:0] pay,
    output logic             overrun
);

    logic             valid_reg;
    logic [PAY_W-1:0] pay_reg;

    // A pulse landing on the issue cycle is accepted: the old entry is
    // leaving, so the new one takes its place (set wins over clear).
    assign overrun = set && valid_reg && !clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            pay_reg   <= '0;
        end else if (set && (!valid_reg || clr)) begin
            valid_reg <= 1'b1;
            pay_reg   <= pay_in;
        end else if (clr) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign pay   = pay_reg;

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one line-request bus master port between the UART debug loader
// (requester 0) and the data-cache fill/writeback path (requester 1).
// Request pulses are parked in four slots ({W,R} x {UART,DC}); the FSM
// grants round-robin between requesters (write before read within one),
// runs one downstream transaction at a time and routes completions and
// read data back to the owner. A timeout aborts a stuck transaction.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   r_wstart_rq/r_win_addr/r_in_wdata/r_in_mask - per-requester write req
//   r_rstart_rq/r_rin_addr           - per-requester read request
//   r_finish_wresp/r_finish_mrd      - per-requester done pulses
//   r_rdat_m_data/r_rdat_m_valid     - read data (shared) + per-owner valid
//   r_busy                           - requester has pending/in-flight work
//   m_*                              - downstream bus master side
//   err_timeout/err_overrun          - sticky error flags
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int             TMO_W      = 16,
    parameter logic [TMO_W-1:0] TMO_CYCLES = {TMO_W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   r_wstart_rq,
    input  logic [63:0]  r_win_addr,
    input  logic [255:0] r_in_wdata,
    input  logic [31:0]  r_in_mask,
    output logic [1:0]   r_finish_wresp,
    input  logic [1:0]   r_rstart_rq,
    input  logic [63:0]  r_rin_addr,
    output logic [127:0] r_rdat_m_data,
    output logic [1:0]   r_rdat_m_valid,
    output logic [1:0]   r_finish_mrd,
    output logic [1:0]   r_busy,
    output logic         m_wstart_rq,
    output logic [31:0]  m_win_addr,
    output logic [127:0] m_in_wdata,
    output logic [15:0]  m_in_mask,
    input  logic         m_finish_wresp,
    output logic         m_rstart_rq,
    output logic [31:0]  m_rin_addr,
    input  logic [127:0] m_rdat_m_data,
    input  logic         m_rdat_m_valid,
    input  logic         m_finish_mrd,
    output logic         err_timeout,
    output logic         err_overrun
);

    arb_state_t       state_reg;
    logic             owner_reg;
    logic             is_write_reg;
    logic             rr_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic [TMO_W-1:0] tmo_inc;

    logic [1:0]        w_valid, r_valid, w_clr, r_clr, w_ovr, r_ovr, pend;
    logic [WPAY_W-1:0] w_pay [N_REQ];
    logic [ADDR_W-1:0] r_pay [N_REQ];
    logic              pick;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            localparam logic ID = 1'(gi);

            assign w_clr[gi] = (state_reg == ISSUE) && (owner_reg == ID) && is_write_reg;
            assign r_clr[gi] = (state_reg == ISSUE) && (owner_reg == ID) && !is_write_reg;

            mem_req_slot #(.PAY_W(WPAY_W)) u_wslot (
                .clk     (clk),
                .rst     (rst),
                .set     (r_wstart_rq[gi]),
                .clr     (w_clr[gi]),
                .pay_in  ({r_win_addr[gi*ADDR_W +: ADDR_W],
                           r_in_wdata[gi*DATA_W +: DATA_W],
                           r_in_mask[gi*MASK_W +: MASK_W]}),
                .valid   (w_valid[gi]),
                .pay     (w_pay[gi]),
                .overrun (w_ovr[gi])
            );

            mem_req_slot #(.PAY_W(ADDR_W)) u_rslot (
                .clk     (clk),
                .rst     (rst),
                .set     (r_rstart_rq[gi]),
                .clr     (r_clr[gi]),
                .pay_in  (r_rin_addr[gi*ADDR_W +: ADDR_W]),
                .valid   (r_valid[gi]),
                .pay     (r_pay[gi]),
                .overrun (r_ovr[gi])
            );

            assign r_busy[gi] = w_valid[gi] || r_valid[gi] ||
                                ((state_reg != IDLE) && (owner_reg == ID));
        end
    endgenerate

    assign pend = w_valid | r_valid;
    // Round-robin: the pointer's requester if it has work, else the other.
    assign pick = pend[rr_reg] ? rr_reg : ~rr_reg;

    assign tmo_inc = (tmo_cnt_reg == {TMO_W{1'b1}}) ? tmo_cnt_reg : tmo_cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            is_write_reg   <= 1'b0;
            rr_reg         <= 1'b0;
            tmo_cnt_reg    <= '0;
            m_wstart_rq    <= 1'b0;
            m_rstart_rq    <= 1'b0;
            m_win_addr     <= '0;
            m_in_wdata     <= '0;
            m_in_mask      <= '0;
            m_rin_addr     <= '0;
            r_finish_wresp <= '0;
            r_finish_mrd   <= '0;
            r_rdat_m_valid <= '0;
            r_rdat_m_data  <= '0;
            err_timeout    <= 1'b0;
            err_overrun    <= 1'b0;
        end else begin
            // Start and completion outputs are single-cycle pulses.
            m_wstart_rq    <= 1'b0;
            m_rstart_rq    <= 1'b0;
            r_finish_wresp <= '0;
            r_finish_mrd   <= '0;
            r_rdat_m_valid <= '0;

            if ((w_ovr | r_ovr) != 2'b00) begin
                err_overrun <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (pend != 2'b00) begin
                        owner_reg    <= pick;
                        is_write_reg <= w_valid[pick];
                        rr_reg       <= ~pick;
                        state_reg    <= ISSUE;
                    end
                end

                ISSUE: begin
                    tmo_cnt_reg <= '0;
                    if (is_write_reg) begin
                        m_wstart_rq <= 1'b1;
                        {m_win_addr, m_in_wdata, m_in_mask} <= w_pay[owner_reg];
                        state_reg   <= WAIT_W;
                    end else begin
                        m_rstart_rq <= 1'b1;
                        m_rin_addr  <= r_pay[owner_reg];
                        state_reg   <= WAIT_R;
                    end
                end

                WAIT_W: begin
                    if (m_finish_wresp) begin
                        r_finish_wresp[owner_reg] <= 1'b1;
                        state_reg                 <= IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_inc;
                        if (tmo_inc == TMO_CYCLES) begin
                            err_timeout               <= 1'b1;
                            r_finish_wresp[owner_reg] <= 1'b1;
                            state_reg                 <= IDLE;
                        end
                    end
                end

                WAIT_R: begin
                    // Beat and finish registered together keep their order.
                    if (m_rdat_m_valid) begin
                        r_rdat_m_data             <= m_rdat_m_data;
                        r_rdat_m_valid[owner_reg] <= 1'b1;
                    end
                    if (m_finish_mrd) begin
                        r_finish_mrd[owner_reg] <= 1'b1;
                        state_reg               <= IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_inc;
                        if (tmo_inc == TMO_CYCLES) begin
                            err_timeout             <= 1'b1;
                            r_finish_mrd[owner_reg] <= 1'b1;
                            state_reg               <= IDLE;
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   r_wstart_rq, r_rstart_rq;
    logic [63:0]  r_win_addr, r_rin_addr;
    logic [255:0] r_in_wdata;
    logic [31:0]  r_in_mask;
    logic [1:0]   r_finish_wresp, r_rdat_m_valid, r_finish_mrd, r_busy;
    logic [127:0] r_rdat_m_data;
    logic         m_wstart_rq, m_rstart_rq;
    logic [31:0]  m_win_addr, m_rin_addr;
    logic [127:0] m_in_wdata, m_rdat_m_data;
    logic [15:0]  m_in_mask;
    logic         m_finish_wresp, m_rdat_m_valid, m_finish_mrd;
    logic         err_timeout, err_overrun;

    mem_req_arbiter #(.TMO_W(16), .TMO_CYCLES(16'd16)) dut (
        .clk            (clk),
        .rst            (rst),
        .r_wstart_rq    (r_wstart_rq),
        .r_win_addr     (r_win_addr),
        .r_in_wdata     (r_in_wdata),
        .r_in_mask      (r_in_mask),
        .r_finish_wresp (r_finish_wresp),
        .r_rstart_rq    (r_rstart_rq),
        .r_rin_addr     (r_rin_addr),
        .r_rdat_m_data  (r_rdat_m_data),
        .r_rdat_m_valid (r_rdat_m_valid),
        .r_finish_mrd   (r_finish_mrd),
        .r_busy         (r_busy),
        .m_wstart_rq    (m_wstart_rq),
        .m_win_addr     (m_win_addr),
        .m_in_wdata     (m_in_wdata),
        .m_in_mask      (m_in_mask),
        .m_finish_wresp (m_finish_wresp),
        .m_rstart_rq    (m_rstart_rq),
        .m_rin_addr     (m_rin_addr),
        .m_rdat_m_data  (m_rdat_m_data),
        .m_rdat_m_valid (m_rdat_m_valid),
        .m_finish_mrd   (m_finish_mrd),
        .err_timeout    (err_timeout),
        .err_overrun    (err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_w;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
        int           at;
    } iss_t;

    typedef struct {
        logic [1:0]   fw;
        logic [1:0]   rv;
        logic [1:0]   fm;
        logic [127:0] data;
        int           at;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    iss_t ie;
    rsp_t re;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int issue_cnt = 0;
    int iss_wait_ptr = 0;

    task automatic chk(input string tag, input logic [175:0] got, input logic [175:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (m_wstart_rq || m_rstart_rq) begin
            issue_cnt = issue_cnt + 1;
            $display("cyc %0d issue %s waddr %h raddr %h", cyc, m_wstart_rq ? "W" : "R", m_win_addr, m_rin_addr);
            if (iss_q.size() == 0) begin
                chk("iss_unexpected", 176'(issue_cnt), 176'(0));
            end else begin
                ie = iss_q.pop_front();
                chk("iss_kind", 176'({m_wstart_rq, m_rstart_rq}), 176'(ie.is_w ? 2'b10 : 2'b01));
                if (ie.is_w) begin
                    chk("iss_waddr", 176'(m_win_addr), 176'(ie.addr));
                    chk("iss_wdata", 176'(m_in_wdata), 176'(ie.data));
                    chk("iss_wmask", 176'(m_in_mask), 176'(ie.mask));
                end else begin
                    chk("iss_raddr", 176'(m_rin_addr), 176'(ie.addr));
                end
                if (ie.at >= 0) chk("iss_cycle", 176'(cyc), 176'(ie.at));
            end
        end
        if ((r_finish_wresp | r_rdat_m_valid | r_finish_mrd) != 2'b00) begin
            $display("cyc %0d resp fw %b rv %b fm %b data %h", cyc, r_finish_wresp, r_rdat_m_valid, r_finish_mrd, r_rdat_m_data);
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 176'({r_finish_wresp, r_rdat_m_valid, r_finish_mrd}), 176'(0));
            end else begin
                re = rsp_q.pop_front();
                chk("rsp_vec", 176'({r_finish_wresp, r_rdat_m_valid, r_finish_mrd}), 176'({re.fw, re.rv, re.fm}));
                if (re.rv != 2'b00) chk("rsp_data", 176'(r_rdat_m_data), 176'(re.data));
                if (re.at >= 0) chk("rsp_cycle", 176'(cyc), 176'(re.at));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_w(input int i, input logic [31:0] a, input logic [127:0] d, input logic [15:0] m);
        r_win_addr[i*32 +: 32]  = a;
        r_in_wdata[i*128 +: 128] = d;
        r_in_mask[i*16 +: 16]   = m;
    endtask

    task automatic set_r(input int i, input logic [31:0] a);
        r_rin_addr[i*32 +: 32] = a;
    endtask

    task automatic push_iss(input logic w, input logic [31:0] a, input logic [127:0] d, input logic [15:0] m, input int at);
        iss_t e;
        e.is_w = w; e.addr = a; e.data = d; e.mask = m; e.at = at;
        iss_q.push_back(e);
    endtask

    task automatic push_rsp(input logic [1:0] fw, input logic [1:0] rv, input logic [1:0] fm, input logic [127:0] d, input int at);
        rsp_t e;
        e.fw = fw; e.rv = rv; e.fm = fm; e.data = d; e.at = at;
        rsp_q.push_back(e);
    endtask

    // One-cycle request pulse; pe returns the index of the sampling edge.
    task automatic pulse(input logic [1:0] w, input logic [1:0] r, output int pe);
        @(negedge clk);
        r_wstart_rq = w;
        r_rstart_rq = r;
        pe = cyc + 1;
        @(negedge clk);
        r_wstart_rq = 2'b00;
        r_rstart_rq = 2'b00;
    endtask

    task automatic wait_issue();
        int target;
        target = iss_wait_ptr + 1;
        for (int k = 0; k < 300 && issue_cnt < target; k++) @(negedge clk);
        chk("issue_wait", 176'(issue_cnt >= target), 176'(1));
        iss_wait_ptr = target;
    endtask

    task automatic wait_cyc(input int n);
        for (int k = 0; k < 1000 && cyc < n; k++) @(negedge clk);
    endtask

    task automatic complete_w(input int owner);
        @(negedge clk);
        m_finish_wresp = 1'b1;
        push_rsp(2'(1 << owner), 2'b00, 2'b00, '0, cyc + 1);
        @(negedge clk);
        m_finish_wresp = 1'b0;
    endtask

    // Read beats; the first beat also carries a stray write completion.
    task automatic read_beats(input int owner, input int n, input logic [127:0] base, input logic fin_same);
        logic last;
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            last = (b == n - 1);
            m_rdat_m_valid = 1'b1;
            m_rdat_m_data  = base + 128'(b);
            m_finish_mrd   = fin_same && last;
            m_finish_wresp = (b == 0);
            push_rsp(2'b00, 2'(1 << owner), (fin_same && last) ? 2'(1 << owner) : 2'b00,
                     base + 128'(b), cyc + 1);
        end
        @(negedge clk);
        m_rdat_m_valid = 1'b0;
        m_finish_mrd   = 1'b0;
        m_finish_wresp = 1'b0;
        if (!fin_same) begin
            m_finish_mrd = 1'b1;
            push_rsp(2'b00, 2'b00, 2'(1 << owner), '0, cyc + 1);
            @(negedge clk);
            m_finish_mrd = 1'b0;
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ctrl"}, 176'({r_finish_wresp, r_rdat_m_valid, r_finish_mrd, r_busy,
                                 m_wstart_rq, m_rstart_rq, err_timeout, err_overrun}), 176'(0));
        chk({tag, "_rdata"}, 176'(r_rdat_m_data), 176'(0));
        chk({tag, "_mpay"}, 176'({m_win_addr, m_rin_addr, m_in_mask}), 176'(0));
        chk({tag, "_mwdata"}, 176'(m_in_wdata), 176'(0));
    endtask

    int pe;

    initial begin
        rst = 1'b1;
        r_wstart_rq = '0; r_rstart_rq = '0;
        r_win_addr = '0; r_rin_addr = '0; r_in_wdata = '0; r_in_mask = '0;
        m_finish_wresp = 1'b0; m_rdat_m_valid = 1'b0; m_finish_mrd = 1'b0;
        m_rdat_m_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b0;

        // Stray completions while idle must not be routed anywhere.
        @(negedge clk);
        m_finish_wresp = 1'b1; m_finish_mrd = 1'b1; m_rdat_m_valid = 1'b1;
        m_rdat_m_data = 128'hDEAD;
        @(negedge clk);
        m_finish_wresp = 1'b0; m_finish_mrd = 1'b0; m_rdat_m_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_idle", 176'({r_finish_wresp, r_rdat_m_valid, r_finish_mrd}), 176'(0));

        // Single UART write.
        set_w(0, 32'h0000_1000, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 16'hFFFF);
        pulse(2'b01, 2'b00, pe);
        push_iss(1'b1, 32'h0000_1000, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 16'hFFFF, pe + 2);
        chk("busy_uart_w", 176'(r_busy), 176'(2'b01));
        wait_issue();
        complete_w(0);
        @(negedge clk);
        chk("busy_after_w", 176'(r_busy), 176'(2'b00));

        // DC read, 4 beats, finish after last beat.
        set_r(1, 32'h0000_2040);
        pulse(2'b00, 2'b10, pe);
        push_iss(1'b0, 32'h0000_2040, '0, '0, pe + 2);
        wait_issue();
        read_beats(1, 4, 128'hCAFE_0000_0000_0000_0000_0000_0000_0100, 1'b0);
        repeat (2) @(negedge clk);

        // Same-cycle UART read + DC write with rr at UART.
        set_r(0, 32'h0000_3000);
        set_w(1, 32'h0000_4000, 128'h4444, 16'h00FF);
        pulse(2'b10, 2'b01, pe);
        push_iss(1'b0, 32'h0000_3000, '0, '0, pe + 2);
        push_iss(1'b1, 32'h0000_4000, 128'h4444, 16'h00FF, -1);
        wait_issue();
        read_beats(0, 1, 128'hA5, 1'b1);
        wait_issue();
        complete_w(1);

        // Lone UART write moves rr to DC; then repeat both pulses: DC first.
        set_w(0, 32'h0000_5000, 128'h5555, 16'h0F0F);
        pulse(2'b01, 2'b00, pe);
        push_iss(1'b1, 32'h0000_5000, 128'h5555, 16'h0F0F, pe + 2);
        wait_issue();
        complete_w(0);
        set_r(0, 32'h0000_3100);
        set_w(1, 32'h0000_4100, 128'h4141, 16'hF000);
        pulse(2'b10, 2'b01, pe);
        push_iss(1'b1, 32'h0000_4100, 128'h4141, 16'hF000, pe + 2);
        push_iss(1'b0, 32'h0000_3100, '0, '0, -1);
        wait_issue();
        complete_w(1);
        wait_issue();
        read_beats(0, 2, 128'hB000, 1'b0);
        repeat (2) @(negedge clk);

        // DC W and R together, overrun pulse, then set-on-issue capture.
        chk("overrun_clear", 176'(err_overrun), 176'(0));
        set_w(1, 32'h0000_6000, 128'h6000, 16'h1111);
        set_r(1, 32'h0000_6100);
        @(negedge clk);
        r_wstart_rq = 2'b10; r_rstart_rq = 2'b10;
        pe = cyc + 1;
        push_iss(1'b1, 32'h0000_6000, 128'h6000, 16'h1111, pe + 2);
        push_iss(1'b1, 32'h0000_6300, 128'h6300, 16'h3333, -1);
        push_iss(1'b0, 32'h0000_6100, '0, '0, -1);
        @(negedge clk);
        set_w(1, 32'h0000_6200, 128'h6200, 16'h2222);
        r_rstart_rq = 2'b00;
        @(negedge clk);
        chk("overrun_set", 176'(err_overrun), 176'(1));
        set_w(1, 32'h0000_6300, 128'h6300, 16'h3333);
        @(negedge clk);
        r_wstart_rq = 2'b00;
        chk("busy_dc", 176'(r_busy), 176'(2'b10));
        wait_issue();
        complete_w(1);
        wait_issue();
        complete_w(1);
        wait_issue();
        read_beats(1, 1, 128'hC0C0, 1'b1);
        repeat (2) @(negedge clk);

        // Timeout on a UART write; a pending DC read follows it.
        set_w(0, 32'h0000_7000, 128'h7000, 16'h7777);
        set_r(1, 32'h0000_7100);
        pulse(2'b01, 2'b10, pe);
        push_iss(1'b1, 32'h0000_7000, 128'h7000, 16'h7777, pe + 2);
        push_rsp(2'b01, 2'b00, 2'b00, '0, pe + 18);
        push_iss(1'b0, 32'h0000_7100, '0, '0, pe + 20);
        wait_cyc(pe + 17);
        chk("tmo_before", 176'(err_timeout), 176'(0));
        wait_cyc(pe + 18);
        chk("tmo_set", 176'(err_timeout), 176'(1));
        wait_issue();
        wait_issue();

        // Reset in the middle of the DC read.
        @(negedge clk);
        m_rdat_m_valid = 1'b1;
        m_rdat_m_data  = 128'hD00D;
        push_rsp(2'b00, 2'b10, 2'b00, 128'hD00D, cyc + 1);
        @(negedge clk);
        m_rdat_m_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outs("midrst");
        rst = 1'b0;
        @(negedge clk);
        m_finish_mrd = 1'b1;
        @(negedge clk);
        m_finish_mrd = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_finish", 176'(r_finish_mrd), 176'(0));

        repeat (3) @(negedge clk);
        chk("iss_q_empty", 176'(iss_q.size()), 176'(0));
        chk("rsp_q_empty", 176'(rsp_q.size()), 176'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
